// File: rtl/cntr_mod_if.sv
// cntr_mod_if -- control/data bundle for the cntr_mod counter.
//   master : drives clr, ce, up, ld, din, cmp; observes out, tc, match
//   slave  : the counter side (inputs/outputs reversed)
// Vector fields are [0:WIDTH-1], so bit 0 is the MSB.
interface cntr_mod_if #(parameter int WIDTH = 16);
   logic             clr;
   logic             ce;
   logic             up;
   logic             ld;
   logic [0:WIDTH-1] din;
   logic [0:WIDTH-1] cmp;
   logic [0:WIDTH-1] out;
   logic             tc;
   logic             match;

   modport master (output clr, ce, up, ld, din, cmp, input out, tc, match);
   modport slave  (input clr, ce, up, ld, din, cmp, output out, tc, match);
endinterface

// File: rtl/cntr_mod.sv
// cntr_mod -- parametrised up/down modulo counter with prescaler.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (clears out, tc, prescaler)
//   bus  : cntr_mod_if.slave
//          clr   sync clear (highest priority)
//          ld    sync load of din, clamped to TOP
//          ce    count enable into the prescaler
//          up    direction, sampled only on the step edge
//          cmp   compare value, match = (out == cmp)
//          out   counter value, tc registered terminal-count pulse
// Optional macro CNTR_SAT_EN: boundary steps saturate instead of wrapping.
module cntr_mod #(
   parameter int              WIDTH    = 16,
   parameter longint unsigned MODULUS  = 0,
   parameter int              PRESCALE = 1
) (
   input logic       clk,
   input logic       rst,
   cntr_mod_if.slave bus
);

   localparam logic [63:0] TOP_L = (MODULUS == 64'd0) ? ((64'd1 << WIDTH) - 64'd1)
                                                      : (MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] TOP      = TOP_L[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] din_v, cmp_v;
   logic [15:0]      pre_q, pre_d;
   logic             tc_q, tc_d;
   logic             step;
   logic             at_bound;

   // [0:W-1] with bit 0 as MSB maps value-for-value onto [W-1:0].
   assign din_v = bus.din;
   assign cmp_v = bus.cmp;

   always_comb begin
      cnt_d    = cnt_q;
      pre_d    = pre_q;
      tc_d     = 1'b0;
      step     = 1'b0;
      at_bound = bus.up ? (cnt_q == TOP) : (cnt_q == '0);

      if (bus.clr) begin
         cnt_d = '0;
         pre_d = '0;
      end else if (bus.ld) begin
         cnt_d = (din_v > TOP) ? TOP : din_v;
         pre_d = '0;
      end else if (bus.ce) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            step  = 1'b1;
         end else begin
            pre_d = pre_q + 16'd1;
         end
      end

      if (step) begin
         // tc marks a step that hit the boundary (wrapped or was blocked).
         tc_d = at_bound;
         if (!at_bound)
            cnt_d = bus.up ? (cnt_q + ONE) : (cnt_q - ONE);
`ifdef CNTR_SAT_EN
         else
            cnt_d = cnt_q;
`else
         else
            cnt_d = bus.up ? '0 : TOP;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         pre_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pre_q <= pre_d;
         tc_q  <= tc_d;
      end
   end

   assign bus.out   = cnt_q;
   assign bus.tc    = tc_q;
   // cnt_q never exceeds TOP, so a cmp above TOP can never match.
   assign bus.match = (cnt_q == cmp_v);

endmodule

// File: tb/tb_cntr_mod.sv
// tb_cntr_mod -- scoreboard bench for cntr_mod.
//   u_a : WIDTH=16 MODULUS=0  PRESCALE=1
//   u_b : WIDTH=4  MODULUS=10 PRESCALE=1
//   u_c : WIDTH=4  MODULUS=10 PRESCALE=4
// Expectations follow CNTR_SAT_EN when the macro is defined.
module tb_cntr_mod;

`ifdef CNTR_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int unsigned TOPS [3] = '{32'hFFFF, 9, 9};
   localparam int unsigned PRES [3] = '{1, 1, 4};

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cntr_mod_if #(.WIDTH(16)) ifa ();
   cntr_mod_if #(.WIDTH(4))  ifb ();
   cntr_mod_if #(.WIDTH(4))  ifc ();

   cntr_mod #(.WIDTH(16), .MODULUS(0),  .PRESCALE(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
   cntr_mod #(.WIDTH(4),  .MODULUS(10), .PRESCALE(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
   cntr_mod #(.WIDTH(4),  .MODULUS(10), .PRESCALE(4)) u_c (.clk(clk), .rst(rst), .bus(ifc));

   typedef struct {
      logic [31:0] out;
      logic        tc;
      logic        match;
   } exp_t;

   exp_t        sb[$];
   int unsigned m_out [3];
   int unsigned m_pre [3];
   logic        m_tc  [3];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] act_out(input int i);
      case (i)
         0:       return 32'(ifa.out);
         1:       return 32'(ifb.out);
         default: return 32'(ifc.out);
      endcase
   endfunction

   function automatic logic [31:0] act_tc(input int i);
      case (i)
         0:       return 32'(ifa.tc);
         1:       return 32'(ifb.tc);
         default: return 32'(ifc.tc);
      endcase
   endfunction

   function automatic logic [31:0] act_match(input int i);
      case (i)
         0:       return 32'(ifa.match);
         1:       return 32'(ifb.match);
         default: return 32'(ifc.match);
      endcase
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_out[i] = 0;
         m_pre[i] = 0;
         m_tc[i]  = 1'b0;
      end
   endfunction

   // Behavioural reference: one clock of counter i given its inputs.
   function automatic void model_step(input int i, input logic c, input logic l,
                                      input logic e, input logic u, input logic [31:0] d);
      m_tc[i] = 1'b0;
      if (c) begin
         m_out[i] = 0;
         m_pre[i] = 0;
      end else if (l) begin
         m_out[i] = (d > TOPS[i]) ? TOPS[i] : d;
         m_pre[i] = 0;
      end else if (e) begin
         if (m_pre[i] + 1 == PRES[i]) begin
            m_pre[i] = 0;
            if (u) begin
               if (m_out[i] == TOPS[i]) begin
                  m_tc[i]  = 1'b1;
                  m_out[i] = SAT ? TOPS[i] : 0;
               end else m_out[i] = m_out[i] + 1;
            end else begin
               if (m_out[i] == 0) begin
                  m_tc[i]  = 1'b1;
                  m_out[i] = SAT ? 0 : TOPS[i];
               end else m_out[i] = m_out[i] - 1;
            end
         end else m_pre[i] = m_pre[i] + 1;
      end
   endfunction

   // Capture inputs, push expectations, clock once, pop and compare.
   task automatic tick();
      logic        c [3], l [3], e [3], u [3];
      logic [31:0] d [3], k [3];
      exp_t        x;
      c = '{ifa.clr, ifb.clr, ifc.clr};
      l = '{ifa.ld,  ifb.ld,  ifc.ld};
      e = '{ifa.ce,  ifb.ce,  ifc.ce};
      u = '{ifa.up,  ifb.up,  ifc.up};
      d = '{32'(ifa.din), 32'(ifb.din), 32'(ifc.din)};
      k = '{32'(ifa.cmp), 32'(ifb.cmp), 32'(ifc.cmp)};
      for (int i = 0; i < 3; i++) begin
         model_step(i, c[i], l[i], e[i], u[i], d[i]);
         x.out   = m_out[i];
         x.tc    = m_tc[i];
         x.match = (m_out[i] == k[i]) && (k[i] <= TOPS[i]);
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         x = sb.pop_front();
         chk($sformatf("sb_out%0d", i),   act_out(i),   x.out);
         chk($sformatf("sb_tc%0d", i),    act_tc(i),    32'(x.tc));
         chk($sformatf("sb_match%0d", i), act_match(i), 32'(x.match));
      end
   endtask

   task automatic idle();
      ifa.clr = 0; ifa.ld = 0; ifa.ce = 0; ifa.up = 1; ifa.din = '0;
      ifb.clr = 0; ifb.ld = 0; ifb.ce = 0; ifb.up = 1; ifb.din = '0;
      ifc.clr = 0; ifc.ld = 0; ifc.ce = 0; ifc.up = 1; ifc.din = '0;
   endtask

   initial begin
      logic [31:0] up_out [3];
      logic        up_tc  [3];
      logic [31:0] dn_out [3];
      logic        dn_tc  [3];
      if (SAT) begin
         up_out = '{9, 9, 9}; up_tc = '{0, 1, 1};
         dn_out = '{0, 0, 0}; dn_tc = '{0, 1, 1};
      end else begin
         up_out = '{9, 0, 1}; up_tc = '{0, 1, 0};
         dn_out = '{0, 9, 8}; dn_tc = '{0, 1, 0};
      end

      idle();
      ifa.cmp = '0; ifb.cmp = '0; ifc.cmp = '0;
      model_reset();
      #12;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_out%0d", i), act_out(i), 0);
         chk($sformatf("rst_tc%0d", i),  act_tc(i),  0);
      end
      @(negedge clk) rst = 1'b1;

      // Async reset mid-count, no clock edge involved.
      ifa.ld = 1; ifa.din = 16'h1234;
      tick();
      idle();
      chk("a_ld_1234", act_out(0), 32'h1234);
      ifa.ce = 1;
      #2 rst = 1'b0;
      #1;
      chk("a_async_rst_out", act_out(0), 0);
      chk("a_async_rst_tc",  act_tc(0),  0);
      model_reset();
      #3 rst = 1'b1;
      repeat (3) tick();
      chk("a_after_rst_3ce", act_out(0), 3);

      // Wrap / saturate upward at TOP.
      idle();
      ifb.ld = 1; ifb.din = 4'd8;
      tick();
      idle();
      ifb.ce = 1; ifb.up = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("b_up_out%0d", k), act_out(1), up_out[k]);
         chk($sformatf("b_up_tc%0d", k),  act_tc(1),  32'(up_tc[k]));
      end
      ifb.up = 0;
      tick();
      chk("b_dir_flip", act_out(1), SAT ? 32'd8 : 32'd0);

      // Wrap / saturate downward at 0.
      idle();
      ifb.ld = 1; ifb.din = 4'd1;
      tick();
      idle();
      ifb.ce = 1; ifb.up = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("b_dn_out%0d", k), act_out(1), dn_out[k]);
         chk($sformatf("b_dn_tc%0d", k),  act_tc(1),  32'(dn_tc[k]));
      end

      // Prescaler divide-by-4, load restarts the prescale count.
      idle();
      ifc.clr = 1;
      tick();
      idle();
      ifc.ce = 1;
      repeat (12) tick();
      chk("c_pre_12ce", act_out(2), 3);
      ifc.clr = 1; ifc.ce = 0;
      tick();
      ifc.clr = 0; ifc.ce = 1;
      repeat (2) tick();
      ifc.ld = 1; ifc.din = 4'd5;
      tick();
      chk("c_ld5", act_out(2), 5);
      ifc.ld = 0;
      repeat (3) tick();
      chk("c_hold_3ce", act_out(2), 5);
      tick();
      chk("c_step_4ce", act_out(2), 6);

      // Priority, clamp, compare.
      idle();
      ifb.ld = 1; ifb.din = 4'd7;
      tick();
      ifb.clr = 1; ifb.ld = 1; ifb.ce = 1; ifb.din = 4'd3;
      tick();
      chk("b_clr_prio", act_out(1), 0);
      idle();
      ifb.ld = 1; ifb.din = 4'd15;
      tick();
      chk("b_ld_clamp", act_out(1), 9);
      idle();
      ifb.cmp = 4'd9;
      #1;
      chk("b_match9", act_match(1), 1);
      ifb.cmp = 4'd12;
      ifb.ce = 1; ifb.up = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("b_nomatch12", act_match(1), 0);
      end

      // Random traffic against the reference model.
      repeat (200) begin
         ifa.clr = ($urandom_range(0, 15) == 0);
         ifa.ld  = ($urandom_range(0, 15) == 0);
         ifa.ce  = ($urandom_range(0, 3) != 0);
         ifa.up  = 1'($urandom);
         ifa.din = 16'($urandom);
         ifa.cmp = 16'($urandom_range(0, 7));
         ifb.clr = ($urandom_range(0, 15) == 0);
         ifb.ld  = ($urandom_range(0, 7) == 0);
         ifb.ce  = ($urandom_range(0, 3) != 0);
         ifb.up  = 1'($urandom);
         ifb.din = 4'($urandom);
         ifb.cmp = 4'($urandom);
         ifc.clr = ($urandom_range(0, 31) == 0);
         ifc.ld  = ($urandom_range(0, 15) == 0);
         ifc.ce  = ($urandom_range(0, 3) != 0);
         ifc.up  = 1'($urandom);
         ifc.din = 4'($urandom);
         ifc.cmp = 4'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
